// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore RAM arbiter: FSM states, buffered write entry
// and the sizing helper for the arbiter's shared down-counter.
package hiscore_pkg;

   localparam int HS_AW = 10;

   typedef enum logic [2:0] {
      IDLE,
      PAUSE_WAIT,
      SETTLE,
      OWN,
      RELEASE
   } arb_state_t;

   typedef struct packed {
      logic [HS_AW-1:0] addr;
      logic [7:0]       data;
   } fifo_entry_t;

   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// Bus between the hiscore engine, game CPU, game work-RAM port and CPU pause
// control. The slave side is the arbiter; the master side is everything around it.
interface hiscore_ram_arbiter_if
   import hiscore_pkg::*;
#(
   parameter int AW = HS_AW
);
   logic [AW-1:0] hs_address;
   logic [7:0]    hs_wdata;
   logic          hs_write;
   logic          hs_access;
   logic [7:0]    hs_rdata;
   logic [AW-1:0] cpu_address;
   logic [7:0]    cpu_wdata;
   logic          cpu_write;
   logic [AW-1:0] ram_address;
   logic [7:0]    ram_wdata;
   logic          ram_write;
   logic [7:0]    ram_rdata;
   logic          pause_req;
   logic          pause_ack;
   logic          granted;
   logic          ack_timeout;
   logic          fifo_overflow;

   modport master (
      output hs_address, hs_wdata, hs_write, hs_access,
      output cpu_address, cpu_wdata, cpu_write,
      output ram_rdata, pause_ack,
      input  hs_rdata, ram_address, ram_wdata, ram_write,
      input  pause_req, granted, ack_timeout, fifo_overflow
   );

   modport slave (
      input  hs_address, hs_wdata, hs_write, hs_access,
      input  cpu_address, cpu_wdata, cpu_write,
      input  ram_rdata, pause_ack,
      output hs_rdata, ram_address, ram_wdata, ram_write,
      output pause_req, granted, ack_timeout, fifo_overflow
   );

endinterface

// File: rtl/hs_write_fifo.sv
// Small synchronous FIFO buffering hiscore writes until the RAM port is owned.
// A push into a full FIFO is accepted only when a pop frees the slot that same cycle.
module hs_write_fifo #(
   parameter int W          = 18,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic         drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [W-1:0]        mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                wr_en;
   logic                rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign drop  = push && full && !rd_en;
   assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the CPU and the hiscore engine by
// pausing the CPU, waiting for ack plus settle time, then granting the port.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | CPU owns the RAM port, no pause requested
// PAUSE_WAIT | pause_req high, waiting for pause_ack or the ack timeout
// SETTLE     | CPU halted, letting its bus settle before taking the port
// OWN        | hiscore owns the port; buffered writes drain first
// RELEASE    | port handed back to the CPU, pause_req dropped
module hiscore_ram_arbiter
   import hiscore_pkg::*;
#(
   parameter int AW              = HS_AW,
   parameter int SETTLE_CYCLES   = 4,
   parameter int RELEASE_IDLE    = 4,
   parameter int ACK_TIMEOUT     = 255,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input logic                  clk,
   input logic                  reset,
   hiscore_ram_arbiter_if.slave bus
);

   localparam int TW = timer_width(ACK_TIMEOUT, SETTLE_CYCLES, RELEASE_IDLE);
   localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

   arb_state_t    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          forced, forced_nxt;
   logic          timeout_hit;
   logic          timer_tc;
   logic          hs_write_q;
   logic          ack_timeout_q;
   logic          overflow_q;
   logic [7:0]    hs_rdata_q;
   logic          own;

   fifo_entry_t   push_entry;
   fifo_entry_t   head_entry;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;

   assign fifo_push  = bus.hs_write && !hs_write_q;
   assign push_entry = '{addr: bus.hs_address, data: bus.hs_wdata};
   assign own        = (state == OWN);
   assign fifo_pop   = own && !fifo_empty;
   assign timer_tc   = (timer <= T_ONE);

   hs_write_fifo #(
      .W          (AW + 8),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         timer         <= '0;
         forced        <= 1'b0;
         hs_write_q    <= 1'b0;
         ack_timeout_q <= 1'b0;
         overflow_q    <= 1'b0;
         hs_rdata_q    <= '0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         forced     <= forced_nxt;
         hs_write_q <= bus.hs_write;
         if (timeout_hit) ack_timeout_q <= 1'b1;
         if (fifo_drop)   overflow_q    <= 1'b1;
         if (own && fifo_empty) hs_rdata_q <= bus.ram_rdata;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      forced_nxt  = forced;
      timeout_hit = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.hs_access || !fifo_empty) begin
               state_nxt = PAUSE_WAIT;
               timer_nxt = TW'(ACK_TIMEOUT);
            end
         end
         PAUSE_WAIT: begin
            if (bus.pause_ack) begin
               state_nxt  = SETTLE;
               timer_nxt  = TW'(SETTLE_CYCLES);
               forced_nxt = 1'b0;
            end else if (ACK_TIMEOUT != 0) begin
               if (timer_tc) begin
                  state_nxt   = SETTLE;
                  timer_nxt   = TW'(SETTLE_CYCLES);
                  forced_nxt  = 1'b1;
                  timeout_hit = 1'b1;
               end else begin
                  timer_nxt = timer - T_ONE;
               end
            end
         end
         SETTLE: begin
            // After a timeout the ack is known to be absent, so only a real ack can drop.
            if (!bus.pause_ack && !forced) begin
               state_nxt = PAUSE_WAIT;
               timer_nxt = TW'(ACK_TIMEOUT);
            end else if (timer_tc) begin
               state_nxt = OWN;
               timer_nxt = TW'(RELEASE_IDLE);
            end else begin
               timer_nxt = timer - T_ONE;
            end
         end
         OWN: begin
            if (bus.hs_access || !fifo_empty) begin
               timer_nxt = TW'(RELEASE_IDLE);
            end else if (timer_tc) begin
               state_nxt = RELEASE;
            end else begin
               timer_nxt = timer - T_ONE;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ram_address = bus.cpu_address;
      bus.ram_wdata   = bus.cpu_wdata;
      bus.ram_write   = bus.cpu_write;
      if (own) begin
         if (!fifo_empty) begin
            bus.ram_address = head_entry.addr;
            bus.ram_wdata   = head_entry.data;
            bus.ram_write   = 1'b1;
         end else begin
            bus.ram_address = bus.hs_address;
            bus.ram_wdata   = bus.hs_wdata;
            bus.ram_write   = 1'b0;
         end
      end
   end

   assign bus.pause_req     = (state == PAUSE_WAIT) || (state == SETTLE) || own;
   assign bus.granted       = own;
   assign bus.hs_rdata      = hs_rdata_q;
   assign bus.ack_timeout   = ack_timeout_q;
   assign bus.fifo_overflow = overflow_q;

endmodule
